// File: rtl/branch_target_predictor.sv
// ----------------------------------------------------------------------------
// branch_target_predictor
//
// Branch predictor with a pattern history table (PHT) of 2-bit saturating
// counters and a direct-mapped branch target buffer (BTB). The PHT is indexed
// either bimodally (MODE=0) or gshare-style (MODE=1, PC XOR global history).
// After reset a CLEAR sweep initialises one entry per cycle. Lookups and
// updates are ignored until the sweep finishes.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active low
//   lookup_pc    fetch address to predict
//   pred_hit     BTB entry valid and tag matches lookup_pc (0 while busy)
//   pred_taken   predicted taken (hit AND counter MSB AND not busy)
//   pred_target  BTB target on a hit, otherwise 0
//   pred_idx     PHT index used for this lookup, returned later as upd_idx
//   upd_en       resolved-branch update strobe
//   upd_pc       address of the resolved branch
//   upd_idx      PHT index captured at lookup time
//   upd_taken    actual outcome
//   upd_target   actual destination
//   busy         table clear sweep in progress
// ----------------------------------------------------------------------------
module branch_target_predictor #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 4,
    parameter int MODE   = 0,
    parameter int GHR_W  = IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    output logic              busy
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
    logic [GHR_W-1:0]   ghr_q, ghr_d;

    logic [1:0]         pht_q    [DEPTH];
    logic [1:0]         pht_d    [DEPTH];
    logic               valid_q  [DEPTH];
    logic               valid_d  [DEPTH];
    logic [TAG_W-1:0]   tag_q    [DEPTH];
    logic [TAG_W-1:0]   tag_d    [DEPTH];
    logic [ADDR_W-1:0]  target_q [DEPTH];
    logic [ADDR_W-1:0]  target_d [DEPTH];

    logic               sweeping;
    logic               upd_accept;
    logic [IDX_W-1:0]   ghr_ext;
    logic [IDX_W-1:0]   lookup_bidx;
    logic [IDX_W-1:0]   upd_bidx;

    // busy also covers the cycle in which rst is low, so outputs are already
    // quiet before the reset edge lands.
    assign busy       = (state_q == CLEAR) || !rst;
    assign sweeping   = (state_q == CLEAR) && rst;
    assign upd_accept = upd_en && !busy;

    assign lookup_bidx = lookup_pc[IDX_W-1:0];
    assign upd_bidx    = upd_pc[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Lookup path: purely combinational from registered tables, so an
    // update in the same cycle is seen only on the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ghr_ext = '0;
        if (MODE == 1) begin
            ghr_ext[GHR_W-1:0] = ghr_q;
        end
        pred_idx    = lookup_bidx ^ ghr_ext;
        pred_hit    = !busy && valid_q[lookup_bidx]
                      && (tag_q[lookup_bidx] == lookup_pc[ADDR_W-1:IDX_W]);
        pred_taken  = pred_hit && pht_q[pred_idx][1];
        pred_target = pred_hit ? target_q[lookup_bidx] : '0;
    end

    // ------------------------------------------------------------------
    // Next-state: FSM, sweep pointer, global history and table writes.
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, otherwise the
    // untaken branches would infer latches.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        ghr_d       = ghr_q;
        pht_d       = pht_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        target_d    = target_q;

        unique case (state_q)
            CLEAR: begin
                if (sweeping) begin
                    pht_d[sweep_idx_q]    = 2'b01;
                    valid_d[sweep_idx_q]  = 1'b0;
                    tag_d[sweep_idx_q]    = '0;
                    target_d[sweep_idx_q] = '0;
                    sweep_idx_d           = sweep_idx_q + IDX_W'(1);
                    if (sweep_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (upd_accept) begin
                    if (upd_taken) begin
                        if (pht_q[upd_idx] != 2'b11) begin
                            pht_d[upd_idx] = pht_q[upd_idx] + 2'd1;
                        end
                        valid_d[upd_bidx]  = 1'b1;
                        tag_d[upd_bidx]    = upd_pc[ADDR_W-1:IDX_W];
                        target_d[upd_bidx] = upd_target;
                    end else if (pht_q[upd_idx] != 2'b00) begin
                        pht_d[upd_idx] = pht_q[upd_idx] - 2'd1;
                    end
                    if (MODE == 1) begin
                        ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers: synchronous active-low reset restarts the sweep.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= CLEAR;
            sweep_idx_q <= '0;
            ghr_q       <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            ghr_q       <= ghr_d;
        end
    end

    // NOTE: the tables carry no reset; the CLEAR sweep initialises them one
    // entry per cycle, which lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        pht_q    <= pht_d;
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

    localparam int ADDR_W = 10;
    localparam int IDX_W  = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] lookup_pc;
    logic              upd_en;
    logic [ADDR_W-1:0] upd_pc;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;

    logic              hit0, taken0, busy0;
    logic [ADDR_W-1:0] target0;
    logic [IDX_W-1:0]  idx0;
    logic              hit1, taken1, busy1;
    logic [ADDR_W-1:0] target1;
    logic [IDX_W-1:0]  idx1;

    always #5 clk = ~clk;

    branch_target_predictor #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .MODE(0)) dut_bimodal (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(hit0), .pred_taken(taken0), .pred_target(target0), .pred_idx(idx0),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .upd_target(upd_target), .busy(busy0)
    );

    branch_target_predictor #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .MODE(1)) dut_gshare (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(hit1), .pred_taken(taken1), .pred_target(target1), .pred_idx(idx1),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_idx(upd_idx),
        .upd_taken(upd_taken), .upd_target(upd_target), .busy(busy1)
    );

    // ------------------------------------------------------------------
    // Reference model: plain integer tables. While busy the table contents
    // are unobservable, so a reset simply wipes everything at once and a
    // countdown tracks how long the sweep keeps the block busy.
    // ------------------------------------------------------------------
    int m_pht   [DEPTH];
    bit m_valid [DEPTH];
    int m_tag   [DEPTH];
    int m_tgt   [DEPTH];
    int m_ghr;
    int m_busy_left;

    typedef struct {
        logic              busy;
        logic              hit;
        logic [ADDR_W-1:0] target;
        logic [IDX_W-1:0]  idx0;
        logic [IDX_W-1:0]  idx1;
        logic              taken0;
        logic              taken1;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model_predict(input logic r, input int pc);
        exp_t e;
        int   bi;
        bi       = pc % DEPTH;
        e.busy   = !r || (m_busy_left > 0);
        e.hit    = !e.busy && m_valid[bi] && (m_tag[bi] == pc / DEPTH);
        e.target = e.hit ? ADDR_W'(m_tgt[bi]) : '0;
        e.idx0   = IDX_W'(bi);
        e.idx1   = IDX_W'(bi ^ (m_ghr % DEPTH));
        e.taken0 = e.hit && (m_pht[e.idx0] >= 2);
        e.taken1 = e.hit && (m_pht[e.idx1] >= 2);
        return e;
    endfunction

    task automatic model_edge(input logic r, input logic ue, input int upc, input int uidx,
                              input logic ut, input int utgt);
        if (!r) begin
            m_busy_left = DEPTH;
            m_ghr       = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_pht[i]   = 1;
                m_valid[i] = 0;
                m_tag[i]   = 0;
                m_tgt[i]   = 0;
            end
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (ue) begin
            if (ut) begin
                m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
                m_valid[upc % DEPTH] = 1;
                m_tag[upc % DEPTH]   = upc / DEPTH;
                m_tgt[upc % DEPTH]   = utgt;
            end else begin
                m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
            end
            m_ghr = ((m_ghr * 2) + int'(ut)) % DEPTH;
        end
    endtask

    // One cycle of stimulus: drive, push the expected lookup result, then
    // let the clock edge happen and advance the model.
    task automatic step(input logic r, input logic [ADDR_W-1:0] lpc, input logic ue,
                        input logic [ADDR_W-1:0] upc, input logic [IDX_W-1:0] uidx,
                        input logic ut, input logic [ADDR_W-1:0] utgt);
        rst        = r;
        lookup_pc  = lpc;
        upd_en     = ue;
        upd_pc     = upc;
        upd_idx    = uidx;
        upd_taken  = ut;
        upd_target = utgt;
        exp_q.push_back(model_predict(r, int'(lpc)));
        @(posedge clk);
        model_edge(r, ue, int'(upc), int'(uidx), ut, int'(utgt));
        #1;
    endtask

    task automatic look(input logic [ADDR_W-1:0] lpc);
        step(1'b1, lpc, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic upd(input logic [ADDR_W-1:0] lpc, input logic [ADDR_W-1:0] upc,
                       input logic [IDX_W-1:0] uidx, input logic ut,
                       input logic [ADDR_W-1:0] utgt);
        step(1'b1, lpc, 1'b1, upc, uidx, ut, utgt);
    endtask

    task automatic do_reset_and_sweep();
        step(1'b0, 10'h025, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) look(10'(i * 37));
    endtask

    // ------------------------------------------------------------------
    // Monitor: every cycle with an outstanding expectation, compare both
    // DUT instances mid-cycle, well away from the rising edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("busy_bimodal",   32'(busy0),   32'(e.busy));
            check("busy_gshare",    32'(busy1),   32'(e.busy));
            check("hit_bimodal",    32'(hit0),    32'(e.hit));
            check("hit_gshare",     32'(hit1),    32'(e.hit));
            check("target_bimodal", 32'(target0), 32'(e.target));
            check("target_gshare",  32'(target1), 32'(e.target));
            check("idx_bimodal",    32'(idx0),    32'(e.idx0));
            check("idx_gshare",     32'(idx1),    32'(e.idx1));
            check("taken_bimodal",  32'(taken0),  32'(e.taken0));
            check("taken_gshare",   32'(taken1),  32'(e.taken1));
        end
    end

    initial begin
        rst        = 1'b0;
        lookup_pc  = '0;
        upd_en     = 1'b0;
        upd_pc     = '0;
        upd_idx    = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        m_busy_left = 0;
        m_ghr       = 0;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 0, 0, 1'b0, 0);
        #1;

        // Reset held for two cycles, then the 16-cycle sweep, then idle lookups.
        step(1'b0, 10'h000, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) look(10'(i));
        look(10'h025);
        look(10'h3ff);

        // Train 0x025 with a same-cycle lookup (old value), then the new value.
        upd(10'h025, 10'h025, 4'd5, 1'b1, 10'h100);
        look(10'h025);
        look(10'h035);

        // Saturation walk on counter 5.
        for (int i = 0; i < 3; i++) upd(10'h025, 10'h025, 4'd5, 1'b1, 10'h100);
        upd(10'h025, 10'h025, 4'd5, 1'b0, 10'h000);
        look(10'h025);
        upd(10'h025, 10'h025, 4'd5, 1'b0, 10'h000);
        look(10'h025);
        for (int i = 0; i < 3; i++) upd(10'h025, 10'h025, 4'd5, 1'b0, 10'h000);
        upd(10'h025, 10'h025, 4'd5, 1'b1, 10'h1a0);
        look(10'h025);

        // Mid-sweep reset at index 9 with updates attempted during the sweep.
        step(1'b0, 10'h025, 1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < 9; i++) upd(10'h025, 10'h025, 4'd5, 1'b1, 10'h2aa);
        step(1'b0, 10'h025, 1'b1, 10'h025, 4'd5, 1'b1, 10'h2aa);
        for (int i = 0; i < DEPTH; i++) upd(10'h025, 10'h025, 4'd5, 1'b1, 10'h2aa);
        look(10'h025);

        // gshare history: T, T, N from a clean GHR, then lookup 0x021.
        do_reset_and_sweep();
        upd(10'h011, 10'h011, 4'd1, 1'b1, 10'h0f0);
        upd(10'h012, 10'h012, 4'd2, 1'b1, 10'h0f4);
        upd(10'h013, 10'h013, 4'd3, 1'b0, 10'h000);
        look(10'h021);
        look(10'h011);

        // Randomised traffic over a small PC pool so tags collide and hit.
        for (int n = 0; n < 600; n++) begin
            logic [ADDR_W-1:0] lpc, upc, utgt;
            logic [IDX_W-1:0]  uidx;
            logic              ue, ut, r;
            lpc  = 10'($urandom_range(0, 63));
            upc  = 10'($urandom_range(0, 63));
            uidx = ($urandom_range(0, 1) == 0) ? upc[IDX_W-1:0] : 4'($urandom_range(0, 15));
            ue   = ($urandom_range(0, 3) != 0);
            ut   = $urandom_range(0, 1) == 1;
            utgt = 10'($urandom);
            r    = ($urandom_range(0, 199) != 0);
            step(r, lpc, ue, upc, uidx, ut, utgt);
        end

        // Drain the scoreboard with a bounded wait.
        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
